// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and the round-robin search used by edge_event_arbiter.
package edge_event_arbiter_pkg;

  localparam int unsigned MAX_CH    = 16;
  localparam int unsigned MAX_IDX_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } grant_t;

  // First set request after ptr, wrapping modulo n.
  function automatic grant_t rr_pick(input logic [MAX_CH-1:0]    req,
                                     input logic [MAX_IDX_W-1:0] ptr,
                                     input int unsigned          n);
    grant_t      g;
    int unsigned j;
    g = '0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      j = (32'(ptr) + k) % n;
      if (k <= n && !g.found && req[j[MAX_IDX_W-1:0]]) begin
        g.found = 1'b1;
        g.idx   = MAX_IDX_W'(j);
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_edge_flag.sv
// Per-channel transition detector: previous-sample register plus post-reset arming.
module edge_flag (
  input  logic Clk,
  input  logic Clr,
  input  logic x,
  input  logic en,
  output logic flag_c,
  output logic level_c
);

  logic prev;
  logic armed;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= x;
      armed <= 1'b1;
    end
  end

  assign flag_c  = armed & en & (x != prev);
  assign level_c = x;

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge detection on N_CH lines, one pending event per channel, round-robin
// arbitration onto a single valid/ready event port.
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [N_CH-1:0]  X,
  input  logic [N_CH-1:0]  Mask,
  output logic             Evt_valid,
  input  logic             Evt_ready,
  output logic [IDX_W-1:0] Evt_ch,
  output logic             Evt_level,
  output logic [CNT_W-1:0] Drop_cnt,
  output logic             Busy
);

  localparam int unsigned      SUM_W   = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0]  edge_c;
  logic [N_CH-1:0]  lvl_c;
  logic [N_CH-1:0]  pending, pending_n;
  logic [N_CH-1:0]  plevel, plevel_n;
  logic [N_CH-1:0]  take_c;
  logic [N_CH-1:0]  drop_c;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] drop_next;
  logic [SUM_W-1:0] drop_sum;
  logic [MAX_CH-1:0] plevel_x;
  grant_t           grant;
  state_t           state, next_state;
  logic             load_c;

  for (genvar i = 0; i < N_CH; i++) begin : g_flag
    edge_flag u_flag (
      .Clk    (Clk),
      .Clr    (Clr),
      .x      (X[i]),
      .en     (Mask[i]),
      .flag_c (edge_c[i]),
      .level_c(lvl_c[i])
    );
  end

  assign grant    = rr_pick(MAX_CH'(pending & Mask), MAX_IDX_W'(rr_ptr), N_CH);
  assign plevel_x = MAX_CH'(plevel);

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant.found) next_state = OFFER;
      OFFER:   if (Evt_ready && !grant.found) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load_c = 1'b0;
    case (state)
      IDLE:    load_c = grant.found;
      OFFER:   load_c = Evt_ready & grant.found;
      default: load_c = 1'b0;
    endcase
  end

  // A fresh edge on the channel being loaded re-arms it rather than dropping.
  always_comb begin
    take_c    = '0;
    drop_c    = '0;
    pending_n = pending;
    plevel_n  = plevel;
    drop_sum  = SUM_W'(Drop_cnt);
    for (int unsigned i = 0; i < N_CH; i++) begin
      take_c[i] = load_c && (grant.idx == MAX_IDX_W'(i));
      drop_c[i] = edge_c[i] & pending[i] & ~take_c[i];
      if (!Mask[i]) begin
        pending_n[i] = 1'b0;
      end else if (edge_c[i] && (!pending[i] || take_c[i])) begin
        pending_n[i] = 1'b1;
        plevel_n[i]  = lvl_c[i];
      end else if (take_c[i]) begin
        pending_n[i] = 1'b0;
      end
      drop_sum = drop_sum + SUM_W'(drop_c[i]);
    end
    drop_next = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(drop_sum);
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      pending   <= '0;
      plevel    <= '0;
      Drop_cnt  <= '0;
      rr_ptr    <= IDX_W'(N_CH - 1);
      Evt_valid <= 1'b0;
      Evt_ch    <= '0;
      Evt_level <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      pending   <= pending_n;
      plevel    <= plevel_n;
      Drop_cnt  <= drop_next;
      Evt_valid <= (next_state == OFFER);
      Busy      <= (next_state == OFFER) | (|pending_n);
      if (load_c) begin
        Evt_ch    <= IDX_W'(grant.idx);
        Evt_level <= plevel_x[grant.idx];
        rr_ptr    <= IDX_W'(grant.idx);
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized and directed bench for edge_event_arbiter against a behavioural event model.
module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int SAT = 255;

  logic       Clk;
  logic       Clr;
  logic [3:0] X;
  logic [3:0] Mask;
  logic       Evt_ready;
  logic       Evt_valid;
  logic [1:0] Evt_ch;
  logic       Evt_level;
  logic [7:0] Drop_cnt;
  logic       Busy;

  int errors = 0;
  int checks = 0;

  edge_event_arbiter #(.N_CH(4), .IDX_W(2), .CNT_W(8)) dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .X        (X),
    .Mask     (Mask),
    .Evt_valid(Evt_valid),
    .Evt_ready(Evt_ready),
    .Evt_ch   (Evt_ch),
    .Evt_level(Evt_level),
    .Drop_cnt (Drop_cnt),
    .Busy     (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: a set of waiting events per channel plus one offered event.
  bit     m_prev [N];
  bit     m_wait [N];
  bit     m_wlvl [N];
  bit     m_armed;
  bit     m_valid;
  int     m_ch;
  bit     m_lvl;
  int     m_drop;
  int     m_last;

  always @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      for (int i = 0; i < N; i++) begin
        m_prev[i] = 0; m_wait[i] = 0; m_wlvl[i] = 0;
      end
      m_armed = 0; m_valid = 0; m_ch = 0; m_lvl = 0; m_drop = 0; m_last = N - 1;
    end else begin
      int  g;
      bit  take;
      int  drops;
      bit  nw [N];
      bit  nl [N];
      g = -1;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (g < 0 && m_wait[j] && Mask[j]) g = j;
      end
      take  = (g >= 0) && (!m_valid || Evt_ready);
      drops = 0;
      for (int i = 0; i < N; i++) begin
        bit changed;
        bit leaving;
        changed = m_armed && Mask[i] && (X[i] != m_prev[i]);
        leaving = take && (g == i);
        nw[i] = m_wait[i];
        nl[i] = m_wlvl[i];
        if (!Mask[i]) nw[i] = 0;
        else if (changed && (!m_wait[i] || leaving)) begin nw[i] = 1; nl[i] = X[i]; end
        else if (changed) drops++;
        else if (leaving) nw[i] = 0;
      end
      if (take) begin
        m_valid = 1; m_ch = g; m_lvl = m_wlvl[g]; m_last = g;
      end else if (m_valid && Evt_ready) begin
        m_valid = 0;
      end
      m_drop = (m_drop + drops > SAT) ? SAT : m_drop + drops;
      for (int i = 0; i < N; i++) begin
        m_wait[i] = nw[i]; m_wlvl[i] = nl[i]; m_prev[i] = X[i];
      end
      m_armed = 1;
    end
  end

  // Compare DUT against the model every cycle, mid-period.
  always @(negedge Clk) begin
    bit any;
    any = 0;
    for (int i = 0; i < N; i++) any |= m_wait[i];
    chk("model_valid", int'(Evt_valid), int'(m_valid));
    if (m_valid) begin
      chk("model_ch", int'(Evt_ch), m_ch);
      chk("model_level", int'(Evt_level), int'(m_lvl));
    end
    chk("model_drop", int'(Drop_cnt), m_drop);
    chk("model_busy", int'(Busy), int'(m_valid | any));
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic do_reset(input logic [3:0] x0, input logic [3:0] m0, input logic r0);
    Clr = 1'b1; X = x0; Mask = m0; Evt_ready = r0;
    tick(); tick();
    Clr = 1'b0;
  endtask

  initial begin
    Clr = 1'b1; X = '0; Mask = 4'hF; Evt_ready = 1'b0;

    // Single rise on ch0: offered one cycle after it becomes pending
    do_reset(4'h0, 4'hF, 1'b0);
    chk("reset_valid", int'(Evt_valid), 0);
    chk("reset_drop", int'(Drop_cnt), 0);
    tick(); tick();
    X = 4'h1;
    tick();
    chk("t1_latency_valid", int'(Evt_valid), 0);
    chk("t1_busy", int'(Busy), 1);
    tick();
    chk("t1_valid", int'(Evt_valid), 1);
    chk("t1_ch", int'(Evt_ch), 0);
    chk("t1_level", int'(Evt_level), 1);
    Evt_ready = 1'b1;
    tick();
    chk("t1_done", int'(Evt_valid), 0);
    Evt_ready = 1'b0;

    // Lines already high at release produce no event
    Clr = 1'b1; X = 4'hF;
    tick();
    Clr = 1'b0;
    tick(); tick(); tick();
    chk("t2_valid", int'(Evt_valid), 0);
    chk("t2_busy", int'(Busy), 0);
    chk("t2_drop", int'(Drop_cnt), 0);

    // Simultaneous rise on all channels drains in round-robin order
    do_reset(4'h0, 4'hF, 1'b1);
    tick(); tick();
    X = 4'hF;
    tick();
    chk("t3_first_valid", int'(Evt_valid), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_valid", int'(Evt_valid), 1);
      chk("t3_ch", int'(Evt_ch), k);
      chk("t3_level", int'(Evt_level), 1);
    end
    tick();
    chk("t3_end", int'(Evt_valid), 0);

    // Three toggles on ch2 under backpressure: one offered, one pending, one dropped
    do_reset(4'h0, 4'hF, 1'b0);
    tick(); tick();
    X = 4'h4; tick();
    X = 4'h0; tick();
    X = 4'h4; tick();
    chk("t4_drop", int'(Drop_cnt), 1);
    chk("t4_valid", int'(Evt_valid), 1);
    chk("t4_ch", int'(Evt_ch), 2);
    chk("t4_level", int'(Evt_level), 1);
    tick();
    chk("t4_hold_ch", int'(Evt_ch), 2);
    chk("t4_hold_level", int'(Evt_level), 1);
    Evt_ready = 1'b1;
    tick();
    chk("t4_second_valid", int'(Evt_valid), 1);
    chk("t4_second_ch", int'(Evt_ch), 2);
    chk("t4_second_level", int'(Evt_level), 0);
    tick();
    chk("t4_end", int'(Evt_valid), 0);
    Evt_ready = 1'b0;

    // Masking ch1 while it is pending discards it
    do_reset(4'h0, 4'hF, 1'b0);
    tick(); tick();
    X = 4'h1; tick();
    tick();
    X = 4'h3; tick();
    Mask = 4'hD; tick();
    X = 4'h1; tick();
    chk("t5_offer_ch", int'(Evt_ch), 0);
    Evt_ready = 1'b1;
    tick();
    chk("t5_valid", int'(Evt_valid), 0);
    chk("t5_busy", int'(Busy), 0);
    Mask = 4'hF;
    tick(); tick();
    chk("t5_no_stale", int'(Evt_valid), 0);
    Evt_ready = 1'b0;

    // Drop counter saturates; reset mid-offer clears everything
    do_reset(4'h0, 4'hF, 1'b0);
    tick(); tick();
    repeat (80) begin
      X = ~X;
      tick();
    end
    chk("t6_sat", int'(Drop_cnt), SAT);
    chk("t6_valid", int'(Evt_valid), 1);
    Clr = 1'b1;
    #1;
    chk("t6_clr_valid", int'(Evt_valid), 0);
    chk("t6_clr_drop", int'(Drop_cnt), 0);
    chk("t6_clr_busy", int'(Busy), 0);
    tick();
    Clr = 1'b0;

    // Randomized traffic
    do_reset(4'h0, 4'hF, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) X = 4'($urandom);
      for (int i = 0; i < N; i++) Mask[i] = ($urandom_range(0, 15) != 0);
      Evt_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
